// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder self-test controller.
// Directed vectors are width-independent patterns, expanded at WIDTH bits by the user.
package adder_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_e;

   // Low-order taps of x^32 + x^22 + x^2 + x + 1; the x^32 term is the shifted-out MSB.
   localparam logic [31:0] LFSR_POLY    = 32'h0040_0007;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

   typedef enum logic [2:0] {
      PAT_ZERO,
      PAT_ONE,
      PAT_ONES,
      PAT_MAX_POS,
      PAT_MIN_NEG
   } pat_e;

   typedef struct packed {
      pat_e a;
      pat_e b;
      logic cin;
   } dir_vec_t;

   localparam dir_vec_t DIR_VEC0 = '{a: PAT_MAX_POS, b: PAT_MAX_POS, cin: 1'b0};
   localparam dir_vec_t DIR_VEC1 = '{a: PAT_MIN_NEG, b: PAT_MIN_NEG, cin: 1'b0};
   localparam dir_vec_t DIR_VEC2 = '{a: PAT_ONES,    b: PAT_ONE,     cin: 1'b0};
   localparam dir_vec_t DIR_VEC3 = '{a: PAT_ZERO,    b: PAT_ONES,    cin: 1'b1};

   typedef struct packed {
      logic sum_ok;
      logic cout_ok;
      logic ovf_ok;
   } cmp_t;

   function automatic dir_vec_t dir_vec(input logic [1:0] idx);
      case (idx)
         2'd0:    return DIR_VEC0;
         2'd1:    return DIR_VEC1;
         2'd2:    return DIR_VEC2;
         default: return DIR_VEC3;
      endcase
   endfunction

endpackage

// File: rtl/adder_bist_lfsr.sv
// Galois LFSR (multiply-by-x modulo the polynomial) with seed load and advance enables.
// One-cycle update; load has priority over advance.
module adder_bist_lfsr
   import adder_bist_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(LFSR_POLY)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             adv_i,
   output logic [WIDTH-1:0] state_o
);

   logic [WIDTH-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED;
      end else if (adv_i) begin
         lfsr_d = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? POLY : '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/adder_bist_ctrl.sv
// Self-test initiator for a combinational adder: APPLY, SETTLE_CYCLES of hold, CHECK per vector.
// Optional first-failure capture ports are built when ADDER_BIST_FIRST_FAIL_EN is defined.
module adder_bist_ctrl
   import adder_bist_pkg::*;
#(
   parameter int          WIDTH         = 32,
   parameter int          NUM_VECTORS   = 256,
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [31:0] SEED          = DEFAULT_SEED,
   localparam int         CW            = $clog2(NUM_VECTORS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   output logic             dut_cin,
   input  logic [WIDTH-1:0] dut_sum,
   input  logic             dut_cout,
   input  logic             dut_overflow,
`ifdef ADDER_BIST_FIRST_FAIL_EN
   output logic             first_fail_valid,
   output logic [CW-1:0]    first_fail_idx,
   output logic [WIDTH-1:0] first_fail_a,
   output logic [WIDTH-1:0] first_fail_b,
   output logic             first_fail_cin,
   output logic [WIDTH-1:0] first_fail_sum,
   output logic [1:0]       first_fail_flags,
`endif
   output logic [CW-1:0]    pass_count,
   output logic [CW-1:0]    fail_count
);

   localparam int SCW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int HALF = WIDTH / 2;

   function automatic logic [WIDTH-1:0] pat_val(input pat_e p);
      logic [WIDTH-1:0] v;
      case (p)
         PAT_ONE:     v = WIDTH'(1);
         PAT_ONES:    v = '1;
         PAT_MAX_POS: v = {1'b0, {(WIDTH-1){1'b1}}};
         PAT_MIN_NEG: v = {1'b1, {(WIDTH-1){1'b0}}};
         default:     v = '0;
      endcase
      return v;
   endfunction

   state_e           state_q, state_d;
   logic [CW-1:0]    idx_q, idx_d, pass_q, pass_d, fail_q, fail_d;
   logic [SCW-1:0]   settle_q, settle_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             cin_q, cin_d, busy_q, busy_d, done_q, done_d;
   logic             lfsr_load, lfsr_adv;
   logic [WIDTH-1:0] lfsr_val;
   logic [WIDTH:0]   full_e;
   logic             ovf_e, vec_ok;
   cmp_t             cmp;
   dir_vec_t         dv;

`ifdef ADDER_BIST_FIRST_FAIL_EN
   typedef struct packed {
      logic             vld;
      logic [CW-1:0]    idx;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH-1:0] sum;
      logic [1:0]       flags;
   } ff_t;
   ff_t ff_q, ff_d;
`endif

   adder_bist_lfsr #(
      .WIDTH (WIDTH),
      .SEED  (WIDTH'(SEED)),
      .POLY  (WIDTH'(LFSR_POLY))
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (lfsr_load),
      .adv_i   (lfsr_adv),
      .state_o (lfsr_val)
   );

   // Golden result is derived from the registered operands, which are stable through CHECK.
   assign full_e      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
   assign ovf_e       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full_e[WIDTH-1] != a_q[WIDTH-1]);
   assign cmp.sum_ok  = (dut_sum == full_e[WIDTH-1:0]);
   assign cmp.cout_ok = (dut_cout == full_e[WIDTH]);
   assign cmp.ovf_ok  = (dut_overflow == ovf_e);
   assign vec_ok      = &cmp;
   assign dv          = dir_vec(idx_q[1:0]);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      settle_d  = settle_q;
      a_d       = a_q;
      b_d       = b_q;
      cin_d     = cin_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      busy_d    = busy_q;
      done_d    = done_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
`ifdef ADDER_BIST_FIRST_FAIL_EN
      ff_d      = ff_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_APPLY;
               idx_d     = '0;
               pass_d    = '0;
               fail_d    = '0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               lfsr_load = 1'b1;
`ifdef ADDER_BIST_FIRST_FAIL_EN
               ff_d      = '0;
`endif
            end
         end
         ST_APPLY: begin
            if (idx_q < CW'(4)) begin
               a_d   = pat_val(dv.a);
               b_d   = pat_val(dv.b);
               cin_d = dv.cin;
            end else begin
               a_d   = lfsr_val;
               b_d   = {lfsr_val[WIDTH-HALF-1:0], lfsr_val[WIDTH-1:WIDTH-HALF]};
               cin_d = lfsr_val[0] ^ lfsr_val[WIDTH-1];
            end
            settle_d = '0;
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == SCW'(SETTLE_CYCLES - 1)) state_d = ST_CHECK;
            else                                      settle_d = settle_q + 1'b1;
         end
         ST_CHECK: begin
            if (vec_ok) pass_d = pass_q + 1'b1;
            else        fail_d = fail_q + 1'b1;
`ifdef ADDER_BIST_FIRST_FAIL_EN
            if (!vec_ok && !ff_q.vld) begin
               ff_d = '{vld: 1'b1, idx: idx_q, a: a_q, b: b_q, cin: cin_q,
                        sum: dut_sum, flags: {dut_cout, dut_overflow}};
            end
`endif
            lfsr_adv = (idx_q >= CW'(4));
            if (idx_q == CW'(NUM_VECTORS - 1)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_APPLY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         pass_q   <= '0;
         fail_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef ADDER_BIST_FIRST_FAIL_EN
         ff_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cin_q    <= cin_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef ADDER_BIST_FIRST_FAIL_EN
         ff_q     <= ff_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign dut_a      = a_q;
   assign dut_b      = b_q;
   assign dut_cin    = cin_q;
   assign pass_count = pass_q;
   assign fail_count = fail_q;
`ifdef ADDER_BIST_FIRST_FAIL_EN
   assign first_fail_valid = ff_q.vld;
   assign first_fail_idx   = ff_q.idx;
   assign first_fail_a     = ff_q.a;
   assign first_fail_b     = ff_q.b;
   assign first_fail_cin   = ff_q.cin;
   assign first_fail_sum   = ff_q.sum;
   assign first_fail_flags = ff_q.flags;
`endif

endmodule

// File: doc/adder_bist_ctrl.md
Name: adder_bist_ctrl

Overview:
- On-chip self-test initiator for the 32-bit adder family: ripple, carry-select, carry-lookahead and carry-skip.
- Generates operand vectors, drives one combinational adder instance, waits a fixed settle time, then checks Sum/Cout/Overflow against an internal golden model.
- Accumulates pass/fail counts and reports done.
- Sits beside the adder under test in silicon-test and FPGA-bringup builds. It is the driving end of the adder A/B/Cin → Sum/Cout/Overflow interface.

Parameters:
- WIDTH, 32, operand width; must be ≥ 2.
- NUM_VECTORS, 256, vectors per run; must be ≥ 4.
- SETTLE_CYCLES, 2, cycles operands are held before sampling results; must be ≥ 1.
- SEED, 32'hACE1_2468, LFSR seed; must be nonzero; only bits [WIDTH-1:0] are used.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a run; sampled only in IDLE or DONE.
- busy, output, 1: run in progress.
- done, output, 1: run complete; held until the next accepted start.
- dut_a, output, WIDTH: operand A to the adder.
- dut_b, output, WIDTH: operand B to the adder.
- dut_cin, output, 1: carry-in to the adder.
- dut_sum, input, WIDTH: adder Sum.
- dut_cout, input, 1: adder Cout.
- dut_overflow, input, 1: adder signed Overflow.
- pass_count, output, CW: vectors that matched; CW = $clog2(NUM_VECTORS+1).
- fail_count, output, CW: vectors that mismatched.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all outputs = 0; LFSR = SEED; vector index = 0.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE or DONE + start:
  - Clear pass_count, fail_count and index; reload LFSR = SEED.
  - done = 0, busy = 1 from the next cycle.
  - Go to APPLY.
- APPLY (1 cycle): register vector[index] onto dut_a/dut_b/dut_cin; go to SETTLE.
- SETTLE: hold operands for SETTLE_CYCLES cycles using an internal counter; then go to CHECK.
- CHECK (1 cycle):
  - Compare dut_sum, dut_cout and dut_overflow with the golden values. Any mismatch increments fail_count; otherwise pass_count increments.
  - Index == NUM_VECTORS-1 → go to DONE with busy = 0, done = 1.
  - Otherwise index++, advance LFSR, go to APPLY.
- Per-vector cost: SETTLE_CYCLES+2 cycles. done rises NUM_VECTORS*(SETTLE_CYCLES+2) cycles after the cycle start is accepted.
- Vector sequence:
  - Directed vectors, indices 0–3:
    - idx 0: A=0x7FFFFFFF, B=0x7FFFFFFF, cin=0
    - idx 1: A=0x80000000, B=0x80000000, cin=0
    - idx 2: A=0xFFFFFFFF, B=0x00000001, cin=0
    - idx 3: A=0x00000000, B=0xFFFFFFFF, cin=1
    - For WIDTH ≠ 32 these are the same patterns at WIDTH bits: max-positive, min-negative, all-ones/one, zero/all-ones.
  - Indices ≥ 4 use the LFSR:
    - A = lfsr.
    - B = lfsr rotated left by WIDTH/2.
    - cin = lfsr[0] ^ lfsr[WIDTH-1].
    - The LFSR is a Galois LFSR with polynomial x^32+x^22+x^2+x+1, advanced once per CHECK of an LFSR vector.
- Golden model:
  - {cout_e, sum_e} = A + B + cin, computed at WIDTH+1 bits, unsigned.
  - ovf_e = (A[MSB] == B[MSB]) && (sum_e[MSB] != A[MSB]).
- start while busy is ignored. start held high in DONE restarts immediately.
- Counters cannot wrap, since pass_count + fail_count ≤ NUM_VECTORS.
- Operands stay stable from APPLY through CHECK. Outside a run they hold their last value.

Optional Feature:
- Macro: ADDER_BIST_FIRST_FAIL_EN.
- With the macro defined, these extra outputs are added:
  - first_fail_valid, 1 bit
  - first_fail_idx, CW bits
  - first_fail_a, WIDTH bits
  - first_fail_b, WIDTH bits
  - first_fail_cin, 1 bit
  - first_fail_sum, WIDTH bits
  - first_fail_flags, 2 bits: {cout, overflow}
- These capture the first mismatching vector and the observed results in CHECK. They are cleared by reset and by an accepted start, and frozen once valid.
- Without the macro, these ports and their registers do not exist.

Decomposition:
- Package adder_bist_pkg holds:
  - the state enum type
  - the LFSR polynomial constant
  - the default SEED
  - the four directed-vector constants
  - the compare-result struct {sum_ok, cout_ok, ovf_ok}
- Sub-module adder_bist_lfsr: WIDTH-parameterised Galois LFSR with load (seed) and advance enables.

Test Plan:
1. Correct ripple_carry_adder, NUM_VECTORS=16, SETTLE_CYCLES=2, pulse start → busy=1 for 64 cycles; done=1; pass_count=16; fail_count=0.
2. Adder model with Cout stuck-at-0, NUM_VECTORS=4 → fail_count=3 (idx 1, 2, 3); pass_count=1. With macro: first_fail_idx=1, first_fail_a=0x80000000, first_fail_sum=0x00000000.
3. Adder model with Overflow stuck-at-0, NUM_VECTORS=4 → fail_count=2 (idx 0, 1). With macro: first_fail_idx=0, first_fail_sum=0xFFFFFFFE, first_fail_flags=2'b00.
4. Pulse start again at cycle 10 of a run → ignored; done still arrives at cycle 64 with unchanged counts.
5. Drive rst_n low mid-run (during vector 5) → all outputs 0 asynchronously. A new start reproduces counts and a dut_a sequence identical to test 1.
6. Carry-select, carry-lookahead and carry-skip adders each run with NUM_VECTORS=256 → fail_count=0. The dut_a sequence for indices ≥ 4 matches the reference LFSR model.
